ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slv_pkg.sv | 45 ++++
 rtl/ahb_slv_bstrb.sv | 23 ++
 rtl/ahb_slave_mem.sv | 142 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slv_pkg.sv
// Shared types and helpers for the AHB-Lite slave memory.
// Holds the htrans encoding, hsize constants, the slave FSM state type and
// the per-lane byte-strobe function used by ahb_slv_bstrb.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } slv_state_e;

  // Widest supported bus is 64 bits: 8 byte lanes addressed by 3 low bits.
  localparam int unsigned BSTRB_MAX_W = 8;
  localparam int unsigned BSTRB_AW    = 3;

  // Returns whether byte lane 'lane' is written for a transfer of 2^size
  // bytes at low address addr_lo on a bus of 2^lg_bytes bytes. Sizes wider
  // than the bus collapse to a full-bus access; the address is aligned down
  // to the transfer size.
  function automatic logic bstrb_lane(input logic [2:0]          size,
                                      input logic [BSTRB_AW-1:0] addr_lo,
                                      input int unsigned         lg_bytes,
                                      input int unsigned         lane);
    int unsigned sz_eff;
    int unsigned nb;
    int unsigned base;
    sz_eff = (32'(size) > lg_bytes) ? lg_bytes : 32'(size);
    nb     = 32'd1 << sz_eff;
    base   = 32'(addr_lo) & ((32'd1 << lg_bytes) - 32'd1) & ~(nb - 32'd1);
    return (lane >= base) && (lane < (base + nb));
  endfunction

endpackage

// File: rtl/ahb_slv_bstrb.sv
// Byte-strobe generator: converts hsize and the low address bits into one
// enable per byte lane of the AHB data bus.
module ahb_slv_bstrb
  import ahb_slv_pkg::*;
#(
  parameter int AHB_DW = 32
) (
  input  logic [2:0]          hsize,
  input  logic [BSTRB_AW-1:0] addr_lo,
  output logic [AHB_DW/8-1:0] bstrb
);

  localparam int unsigned LG_BYTES = $clog2(AHB_DW / 8);

  // One strobe bit per lane, evaluated independently.
  always_comb begin
    bstrb = '0;
    for (int i = 0; i < AHB_DW / 8; i++) begin
      bstrb[i] = bstrb_lane(hsize, addr_lo, LG_BYTES, unsigned'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with an internal word memory.
// Optional wait states: define AHB_SLV_WAIT_EN to insert WAIT_CYC wait
// cycles in every data phase; otherwise hready is permanently high.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no data phase pending, hready=1
// ST_WAIT | data phase pending, hready=0 while the wait counter runs
// ST_DATA | data phase completes this cycle, hready=1
module ahb_slave_mem
  import ahb_slv_pkg::*;
#(
  parameter int AHB_DW    = 32,
  parameter int AHB_AW    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AHB_AW-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [AHB_DW-1:0] hwdata,
  output logic [AHB_DW-1:0] hrdata,
  output logic              hready
);

  localparam int IDX_LO = $clog2(AHB_DW / 8);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int NBYTES = AHB_DW / 8;

`ifdef AHB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);
`else
  localparam logic [3:0] WAIT_LD = 4'd0;
  localparam int unused_wait_cyc = WAIT_CYC;
`endif

  slv_state_e        state_q;
  slv_state_e        state_nxt;
  logic [3:0]        wait_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [2:0]        lo_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic              accept;
  logic              mem_we;
  logic [NBYTES-1:0] bstrb;

  logic [AHB_DW-1:0] mem [MEM_DEPTH];

  // hburst and htrans[0] do not affect this slave; upper haddr bits wrap.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0], haddr};

  assign accept = hready && htrans[1];
  assign mem_we = (state_q == ST_DATA) && write_q;

  ahb_slv_bstrb #(
    .AHB_DW (AHB_DW)
  ) u_bstrb (
    .hsize   (size_q),
    .addr_lo (lo_q),
    .bstrb   (bstrb)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and bus outputs; a new address phase can be taken in ST_DATA
  // so back-to-back transfers need no idle cycle.
  always_comb begin
    state_nxt = state_q;
    hready    = 1'b1;
    hrdata    = '0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (state_q == ST_DATA && !write_q) begin
          hrdata = mem[idx_q];
        end
        if (accept) begin
          state_nxt = (WAIT_LD != 4'd0) ? ST_WAIT : ST_DATA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hready = 1'b0;
        if (wait_cnt_q <= 4'd1) begin
          state_nxt = ST_DATA;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address-phase capture and wait down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      lo_q       <= 3'd0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt_q <= WAIT_LD;
        idx_q      <= haddr[IDX_LO +: IDX_W];
        lo_q       <= haddr[2:0];
        size_q     <= hsize;
        write_q    <= hwrite;
      end else if (state_q == ST_WAIT && wait_cnt_q != 4'd0) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end else if (state_q == ST_DATA) begin
        write_q <= 1'b0;
      end
    end
  end

  // Strobed byte write at the edge ending a write data phase; no reset on
  // the array so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bstrb[b]) begin
          mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: directed scenarios plus random
// AHB traffic, compared against a byte-array memory model.
module tb_ahb_slave_mem;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;

  ahb_slave_mem #(
    .AHB_DW    (DW),
    .AHB_AW    (AW),
    .MEM_DEPTH (DEPTH),
    .WAIT_CYC  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .haddr   (haddr),
    .htrans  (htrans),
    .hwrite  (hwrite),
    .hsize   (hsize),
    .hburst  (hburst),
    .hwdata  (hwdata),
    .hrdata  (hrdata),
    .hready  (hready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-level memory model.
  logic [7:0] mb [DEPTH*4];

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int unsigned w;
    w = widx(a) * 4;
    return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int unsigned nb, base, w;
    nb   = (sz >= 3'd2) ? 4 : (1 << sz);
    base = ((a % 4) / nb) * nb;
    w    = widx(a) * 4;
    for (int unsigned k = 0; k < nb; k++) begin
      mb[w + base + k] = d[8*(base+k) +: 8];
    end
  endtask

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] last_rd;
  int          last_waits;

  task automatic push(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] d);
    xfer_t x;
    x.tr = tr; x.wr = wr; x.addr = a; x.sz = sz; x.wdata = d;
    q.push_back(x);
  endtask

  // Pipelined master: drives address phases from the queue and checks each
  // cycle's hready/hrdata against the expected wait count and the model.
  task automatic run_q();
    xfer_t ap, dp;
    bit    dp_v;
    int    wl, stall;
    dp_v = 0; wl = 0; stall = 0;
    while (q.size() > 0 || dp_v) begin
      if (q.size() > 0) begin
        ap = q[0];
      end else begin
        ap.tr = 2'd0; ap.wr = 1'b0; ap.addr = $urandom; ap.sz = 3'd2; ap.wdata = '0;
      end
      htrans = ap.tr; haddr = ap.addr; hwrite = ap.wr; hsize = ap.sz; hburst = 3'd1;
      hwdata = dp_v ? dp.wdata : $urandom;
      @(negedge clk);
      if (dp_v && wl > 0) begin
        chk("hready_wait", {31'd0, hready}, 32'd0);
        chk("hrdata_wait", hrdata, 32'd0);
      end else begin
        chk("hready", {31'd0, hready}, 32'd1);
        if (dp_v) begin
          if (dp.wr) begin
            model_wr(dp.addr, dp.sz, dp.wdata);
          end else begin
            chk("hrdata", hrdata, model_rd(dp.addr));
            last_rd = hrdata;
          end
          last_waits = stall;
        end else begin
          chk("hrdata_idle", hrdata, 32'd0);
        end
      end
      if (hready === 1'b1) begin
        stall = 0;
        if (ap.tr[1]) begin
          dp = ap; dp_v = 1; wl = EXP_WAIT;
        end else begin
          dp_v = 0;
        end
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        if (wl > 0) wl--;
        stall++;
        if (stall > 40) begin
          chk("hready_timeout", 32'(stall), 32'd0);
          q.delete();
          dp_v = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    htrans = 2'd0;
  endtask

  logic [31:0] burst_d [4];
  logic [31:0] old_w;

  initial begin
    htrans = 2'd0; haddr = '0; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hwdata = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready", {31'd0, hready}, 32'd1);
    chk("rst_hrdata", hrdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) push(2'd2, 1'b1, 32'(i * 4), 3'd2, $urandom);
    run_q();

    push(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    run_q();
    chk("single_wr_rd", last_rd, 32'hDEADBEEF);

    push(2'd2, 1'b1, 32'h10, 3'd2, 32'h11223344);
    push(2'd2, 1'b1, 32'h13, 3'd0, 32'hAB000000);
    push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    run_q();
    chk("byte_wr", last_rd, 32'hAB223344);

    push(2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    run_q();
    chk("rd_waits", 32'(last_waits), 32'(EXP_WAIT));
    chk("rd_wait_data", last_rd, 32'hAB223344);

    push(2'd2, 1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
    push(2'd2, 1'b0, 32'h000, 3'd2, 32'h0);
    run_q();
    chk("addr_wrap", last_rd, 32'hCAFEF00D);

    burst_d[0] = 32'hA0A0A0A0; burst_d[1] = 32'hA1A1A1A1;
    burst_d[2] = 32'hA2A2A2A2; burst_d[3] = 32'hA3A3A3A3;
    push(2'd2, 1'b1, 32'h40, 3'd2, burst_d[0]);
    push(2'd3, 1'b1, 32'h44, 3'd2, burst_d[1]);
    push(2'd1, 1'b1, 32'h48, 3'd2, 32'h0);
    push(2'd3, 1'b1, 32'h48, 3'd2, burst_d[2]);
    push(2'd3, 1'b1, 32'h4C, 3'd2, burst_d[3]);
    run_q();
    for (int k = 0; k < 4; k++) begin
      push(2'd2, 1'b0, 32'(32'h40 + 4 * k), 3'd2, 32'h0);
      run_q();
      chk("burst_rd", last_rd, burst_d[k]);
    end

    old_w = model_rd(32'h20);
    htrans = 2'd2; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    htrans = 2'd0; hwdata = 32'h5A5A5A5A;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_hready", {31'd0, hready}, 32'd1);
    chk("midrst_hrdata", hrdata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    push(2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    run_q();
    chk("midrst_mem", last_rd, old_w);

    repeat (400) begin
      push(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 2047)),
           3'($urandom_range(0, 3)), $urandom);
    end
    run_q();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
